// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO for a UART: edge-detects the receiver's ready level into
// single pushes, buffers bytes first-word fall-through and flags dropped bytes.
module uart_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_data_ready,
  input  logic          rd_en,
  input  logic          flush,
  input  logic          ovr_clr,
  input  logic [AW:0]   threshold,
  output logic [7:0]    rd_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overrun,
  output logic          rx_irq
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE        = (AW+1)'(1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          rdy_d;
  logic          push_evt;
  logic          do_pop;
  logic          do_push;
  logic          drop;

  assign push_evt = rx_data_ready && !rdy_d;
  assign do_pop   = rd_en && !empty && !flush;
  // A full FIFO still accepts a byte when the same cycle frees a slot.
  assign do_push  = push_evt && !flush && (!full || do_pop);
  assign drop     = push_evt && !flush && full && !do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign rx_irq  = (threshold != '0) && (count >= threshold);
  assign rd_data = empty ? 8'h00 : mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= rx_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      rdy_d   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      rdy_d <= rx_data_ready;
      if (flush) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (do_push) begin
          wptr <= wptr + 1'b1;
        end
        if (do_pop) begin
          rptr <= rptr + 1'b1;
        end
        if (do_push && !do_pop) begin
          count <= count + ONE;
        end else if (do_pop && !do_push) begin
          count <= count - ONE;
        end
      end
      // Setting wins over a simultaneous clear so no drop goes unreported.
      if (drop) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a queue-based model is checked every cycle,
// with literal expectations pinning the key scenarios.
module tb_uart_rx_fifo;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_data_ready;
  logic          rd_en;
  logic          flush;
  logic          ovr_clr;
  logic [AW:0]   threshold;
  logic [7:0]    rd_data;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic          overrun;
  logic          rx_irq;

  int errors = 0;
  int checks = 0;

  logic [7:0] q [$];
  bit         m_rdy_d;
  bit         m_ovr;
  bit         m_push;
  bit         m_pop;
  bit         m_full;
  bit         m_set;

  uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_data       (rx_data),
    .rx_data_ready (rx_data_ready),
    .rd_en         (rd_en),
    .flush         (flush),
    .ovr_clr       (ovr_clr),
    .threshold     (threshold),
    .rd_data       (rd_data),
    .empty         (empty),
    .full          (full),
    .count         (count),
    .overrun       (overrun),
    .rx_irq        (rx_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input logic rdy, input logic [7:0] d, input logic rd,
                                input logic fl, input logic oc);
    @(posedge clk);
    #1;
    rx_data_ready = rdy;
    rx_data       = d;
    rd_en         = rd;
    flush         = fl;
    ovr_clr       = oc;
  endtask

  task automatic idle();
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push_byte(input logic [7:0] d);
    apply_stimulus(1'b1, d, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, d, 1'b0, 1'b0, 1'b0);
  endtask

  // Model: the FIFO as a queue, one push per rising edge of ready.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      m_rdy_d = 1'b0;
      m_ovr   = 1'b0;
    end else begin
      m_push = rx_data_ready && !m_rdy_d;
      m_pop  = rd_en && (q.size() != 0);
      m_set  = 1'b0;
      if (flush) begin
        q.delete();
      end else begin
        m_full = (q.size() == DEPTH);
        if (m_pop) void'(q.pop_front());
        if (m_push) begin
          if (!m_full || m_pop) q.push_back(rx_data);
          else m_set = 1'b1;
        end
      end
      if (m_set) m_ovr = 1'b1;
      else if (ovr_clr) m_ovr = 1'b0;
      m_rdy_d = rx_data_ready;
    end
  end

  always @(negedge clk) begin
    check_output("count", 32'(count), 32'(q.size()));
    check_output("count_max", 32'(count <= 4'(DEPTH)), 32'd1);
    check_output("empty", 32'(empty), 32'(q.size() == 0));
    check_output("full", 32'(full), 32'(q.size() == DEPTH));
    check_output("rd_data", 32'(rd_data), (q.size() == 0) ? 32'h0 : 32'(q[0]));
    check_output("overrun", 32'(overrun), 32'(m_ovr));
    check_output("rx_irq", 32'(rx_irq),
                 32'((threshold != 0) && (q.size() >= int'(threshold))));
  end

  logic [7:0] exp_rd [8];

  initial begin
    rst = 1'b0;
    rx_data = 8'h00;
    rx_data_ready = 1'b0;
    rd_en = 1'b0;
    flush = 1'b0;
    ovr_clr = 1'b0;
    threshold = '0;
    @(negedge clk);
    check_output("rst_empty", 32'(empty), 32'd1);
    check_output("rst_full", 32'(full), 32'd0);
    check_output("rst_rd_data", 32'(rd_data), 32'h00);
    check_output("rst_irq", 32'(rx_irq), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Single byte with ready held high
    for (int i = 0; i < 16; i++) apply_stimulus(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    check_output("single_count", 32'(count), 32'd1);
    check_output("single_data", 32'(rd_data), 32'hA5);
    check_output("single_irq_thr0", 32'(rx_irq), 32'd0);
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    check_output("single_empty", 32'(empty), 32'd1);

    // Fill, then overflow
    for (int i = 0; i < 8; i++) push_byte(8'(i));
    push_byte(8'hFF);
    idle();
    @(negedge clk);
    check_output("fill_full", 32'(full), 32'd1);
    check_output("fill_overrun", 32'(overrun), 32'd1);
    check_output("fill_head", 32'(rd_data), 32'h00);
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    idle();
    @(negedge clk);
    check_output("ovr_cleared", 32'(overrun), 32'd0);

    // Push and pop together while full
    apply_stimulus(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    check_output("fullpp_count", 32'(count), 32'd8);
    check_output("fullpp_overrun", 32'(overrun), 32'd0);
    exp_rd = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h55};
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      check_output("read_order", 32'(rd_data), 32'(exp_rd[i]));
    end
    idle();
    @(negedge clk);
    check_output("drain_empty", 32'(empty), 32'd1);

    // Wrap: push/pop pairs with extra reads, including pops while empty
    push_byte(8'h80);
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(1'b1, 8'(8'h90 + i), 1'b1, 1'b0, 1'b0);
      apply_stimulus(1'b0, 8'h00, (i % 3) == 0, 1'b0, 1'b0);
      if ((i % 4) == 1) begin
        push_byte(8'(8'hD0 + i));
        push_byte(8'(8'hE0 + i));
      end
    end
    for (int i = 0; i < 12; i++) apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    idle();

    // Threshold interrupt
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    threshold = 4'd4;
    for (int i = 0; i < 3; i++) push_byte(8'(8'h40 + i));
    idle();
    @(negedge clk);
    check_output("thr_irq3", 32'(rx_irq), 32'd0);
    push_byte(8'h43);
    idle();
    @(negedge clk);
    check_output("thr_irq4", 32'(rx_irq), 32'd1);
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    check_output("thr_irq_pop", 32'(rx_irq), 32'd0);

    // Flush coincident with push; held ready must not re-push afterwards
    apply_stimulus(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0);
    apply_stimulus(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    check_output("flush_count", 32'(count), 32'd0);
    check_output("flush_overrun", 32'(overrun), 32'd0);

    // Clear coincident with an overflowing push: set wins
    for (int i = 0; i < 8; i++) push_byte(8'(8'hC0 + i));
    apply_stimulus(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
    idle();
    @(negedge clk);
    check_output("ovr_set_wins", 32'(overrun), 32'd1);
    check_output("ovr_count", 32'(count), 32'd8);

    // Reset mid-operation, released with ready already high
    @(posedge clk);
    #1;
    rst = 1'b0;
    rx_data_ready = 1'b1;
    rx_data = 8'h3C;
    @(negedge clk);
    check_output("midrst_empty", 32'(empty), 32'd1);
    check_output("midrst_rd_data", 32'(rd_data), 32'h00);
    check_output("midrst_overrun", 32'(overrun), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    check_output("rel_count", 32'(count), 32'd1);
    check_output("rel_data", 32'(rd_data), 32'h3C);

    idle();
    idle();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning the number of byte entries; it must be a power of two, 2..256.
REQ-002 SHALL have parameter AW, default 3, meaning the pointer width; AW = log2(DEPTH).
REQ-003 clk  input  1  single clock for all state; also clocks the receiver that drives rx_data/rx_data_ready.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 rx_data  input  8  received byte; valid whenever rx_data_ready=1.
REQ-006 rx_data_ready  input  1  level from the receiver; may stay high for many cycles per byte.
REQ-007 rd_en  input  1  pops the head entry when empty=0.
REQ-008 flush  input  1  synchronous clear of the FIFO contents.
REQ-009 ovr_clr  input  1  clears the sticky overrun flag.
REQ-010 threshold  input  AW+1  interrupt level, 1..DEPTH.
REQ-011 rd_data  output  8  head entry, first-word fall-through; 8'h00 when empty.
REQ-012 empty  output  1  FIFO holds 0 entries.
REQ-013 full  output  1  FIFO holds DEPTH entries.
REQ-014 count  output  AW+1  number of entries held, 0..DEPTH.
REQ-015 overrun  output  1  sticky flag: a byte was dropped.
REQ-016 rx_irq  output  1  level interrupt; high when count >= threshold and threshold != 0.

Function
REQ-017 SHALL register rx_data_ready into rdy_d (reset 0); a push event is rx_data_ready=1 and rdy_d=0, giving one push per byte regardless of how long ready is held.
REQ-018 On a push event with the FIFO not full, SHALL write rx_data into mem[wptr] at that clock edge, then wptr+1 (mod DEPTH) and count+1.
REQ-019 Push latency: empty SHALL fall, and rd_data SHALL show the byte, in the cycle after the push edge.
REQ-020 On rd_en=1 with empty=0, SHALL advance rptr+1 (mod DEPTH) and decrement count; rd_data SHALL present the next entry in the following cycle.
REQ-021 rd_en with empty=1 SHALL be ignored; there is no underflow flag and no state change.
REQ-022 Push and pop in the same cycle with 0 < count < DEPTH: both SHALL take effect and count SHALL be unchanged.
REQ-023 Push and pop in the same cycle with count=DEPTH: both SHALL take effect, the byte SHALL be stored, count SHALL stay DEPTH, and overrun SHALL be unchanged.
REQ-024 Push and pop in the same cycle with count=0: the pop SHALL be ignored and the push SHALL take effect, giving count=1.
REQ-025 A push event with count=DEPTH and no pop SHALL drop the byte, leave mem and pointers unchanged, and set overrun.
REQ-026 overrun SHALL stay set until ovr_clr=1; if the set condition and ovr_clr occur in the same cycle, set SHALL win.
REQ-027 flush=1 SHALL set wptr=rptr=0 and count=0 at the next edge, with priority over push and pop in that cycle.
REQ-028 A push event coincident with flush SHALL be discarded and SHALL NOT set overrun; rdy_d SHALL still update.
REQ-029 Pointer wrap: wptr and rptr SHALL wrap from DEPTH-1 to 0 with no gap or reuse error.
REQ-030 full, empty and rx_irq SHALL be derived combinationally from count; count SHALL never exceed DEPTH.
REQ-031 There is no parity/error handling here; the receiver suppresses bad-parity bytes.

Reset
REQ-032 While rst=0 SHALL asynchronously force: wptr=rptr=0, count=0, rdy_d=0, overrun=0.
REQ-033 Resulting output values under reset SHALL be: empty=1, full=0, rd_data=8'h00, rx_irq=0.
REQ-034 Memory contents need no reset.
REQ-035 Reset asserted mid-operation SHALL discard all entries.
REQ-036 After reset release, a rx_data_ready already high SHALL count as one push, since rdy_d=0.

Verification
REQ-037 Scenario single byte: hold ready high 16 cycles with rx_data=8'hA5 -> count=1, rd_data=8'hA5; pop -> empty=1.
REQ-038 Scenario fill: push 8'h00..8'h07 (DEPTH=8) -> full=1; push 8'hFF -> overrun=1, reads return 00..07 in order.
REQ-039 Scenario full push+pop: with count=8 issue push 8'h55 and rd_en together -> count=8, overrun=0, 8'h55 is the last read.
REQ-040 Scenario wrap: 20 push/pop pairs with interleaved reads -> data order preserved, count never exceeds 8.
REQ-041 Scenario threshold=4: 3 pushes -> rx_irq=0; 4th push -> rx_irq=1; one pop -> rx_irq=0.
REQ-042 Scenario flush+push and ovr_clr: flush coincident with push -> count=0, overrun=0; ovr_clr coincident with overrun push -> overrun=1.
